// File: rtl/huff_pkg.sv
// Shared types and constants for the Huffman encoder phase controller.
// Holds bin count, count width, symbol index width, phase enum and leaf struct.
package huff_pkg;

   localparam int NSYM = 128;
   localparam int CW   = 16;
   localparam int IW   = $clog2(NSYM);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_COUNT,
      S_SCAN,
      S_WAIT_TREE,
      S_DONE
   } huff_phase_t;

   typedef struct packed {
      logic [IW-1:0] sym;
      logic [CW-1:0] freq;
   } huff_leaf_t;

endpackage

// File: rtl/leaf_out_reg.sv
// Single-entry valid/ready output register for the leaf stream.
// Ports: clk, reset, load_i/data_i (new leaf), ready_i (sink accepts),
//        valid_o/data_o (held while stalled), slot_free_o (may load this cycle).
module leaf_out_reg
   import huff_pkg::*;
#(
   parameter int W = $bits(huff_leaf_t)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   input  logic         ready_i,
   output logic         valid_o,
   output logic [W-1:0] data_o,
   output logic         slot_free_o
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   // Slot is reusable when empty or when the current leaf leaves this cycle.
   assign slot_free_o = !valid_q || ready_i;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (slot_free_o) begin
         valid_d = load_i;
         if (load_i) data_d = data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/huffman_phase_ctrl.sv
// Phase sequencer for the Huffman front end: clear, count, scan table, wait tree.
// Ports: clk, reset, start, HREADY, finish_cnt, curr_count, leaf_ready, tree_done in;
//        count_clear, count_enable, leaf_valid/sym/freq, num_leaves, busy, done,
//        error out. Define HUFF_PAD_SINGLE_EN to pad a single-leaf pass to two leaves.
module huffman_phase_ctrl #(
   parameter int NSYM = huff_pkg::NSYM,
   parameter int CW   = huff_pkg::CW
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      HREADY,
   input  logic                      finish_cnt,
   input  logic [NSYM-1:0][CW-1:0]   curr_count,
   input  logic                      leaf_ready,
   input  logic                      tree_done,
   output logic                      count_clear,
   output logic                      count_enable,
   output logic                      leaf_valid,
   output logic [$clog2(NSYM)-1:0]   leaf_sym,
   output logic [CW-1:0]             leaf_freq,
   output logic [7:0]                num_leaves,
   output logic                      busy,
   output logic                      done,
   output logic                      error
);

   import huff_pkg::huff_phase_t;
   import huff_pkg::huff_leaf_t;
   import huff_pkg::S_IDLE;
   import huff_pkg::S_CLEAR;
   import huff_pkg::S_COUNT;
   import huff_pkg::S_SCAN;
   import huff_pkg::S_WAIT_TREE;
   import huff_pkg::S_DONE;

   localparam int         SW      = $clog2(NSYM);
   localparam logic [7:0] IDX_END = 8'(NSYM);

   huff_phase_t state_q;
   logic [7:0]  idx_q;
   logic [7:0]  num_q;
   logic        err_q;

   logic        slot_free;
   logic        idx_end;
   logic        entry_nz;
   logic        pad_need;
   logic        load_d;
   logic        scan_exit;
   huff_leaf_t  leaf_d;
   huff_leaf_t  leaf_q;

   assign idx_end  = (idx_q == IDX_END);
   assign entry_nz = !idx_end && (curr_count[idx_q[SW-1:0]] != '0);

`ifdef HUFF_PAD_SINGLE_EN
   // A lone leaf gets a zero-frequency partner so the tree has two inputs.
   assign pad_need = idx_end && (num_q == 8'd1);
`else
   assign pad_need = 1'b0;
`endif

   assign load_d    = (state_q == S_SCAN) && slot_free
                      && (entry_nz || pad_need);
   assign scan_exit = (state_q == S_SCAN) && idx_end
                      && slot_free && !pad_need;

   always_comb begin
      leaf_d.sym  = idx_q[SW-1:0];
      leaf_d.freq = curr_count[idx_q[SW-1:0]];
      if (pad_need) begin
         leaf_d.sym  = leaf_q.sym + SW'(1);
         leaf_d.freq = '0;
      end
   end

   leaf_out_reg u_leaf (
      .clk         (clk),
      .reset       (reset),
      .load_i      (load_d),
      .data_i      (leaf_d),
      .ready_i     (leaf_ready),
      .valid_o     (leaf_valid),
      .data_o      (leaf_q),
      .slot_free_o (slot_free)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         num_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) state_q <= S_CLEAR;
            end
            S_CLEAR: begin
               idx_q   <= '0;
               num_q   <= '0;
               err_q   <= 1'b0;
               state_q <= S_COUNT;
            end
            S_COUNT: begin
               if (finish_cnt) begin
                  idx_q   <= '0;
                  state_q <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (slot_free && !idx_end) idx_q <= idx_q + 8'd1;
               if (load_d) num_q <= num_q + 8'd1;
               if (scan_exit) begin
                  if (num_q == 8'd0) begin
                     err_q   <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     state_q <= S_WAIT_TREE;
                  end
               end
            end
            S_WAIT_TREE: begin
               if (tree_done) state_q <= S_DONE;
            end
            S_DONE: begin
               if (start) begin
                  err_q   <= 1'b0;
                  state_q <= S_CLEAR;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Enable drops in the finish_cnt cycle so the last count is not doubled.
   assign count_enable = (state_q == S_COUNT) && HREADY && !finish_cnt;
   assign count_clear  = (state_q == S_CLEAR);
   assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done         = (state_q == S_DONE);
   assign error        = err_q;
   assign num_leaves   = num_q;
   assign leaf_sym     = leaf_q.sym;
   assign leaf_freq    = leaf_q.freq;

endmodule

// File: tb/tb_huffman_phase_ctrl.sv
// Self-checking bench for huffman_phase_ctrl using an expected-leaf queue.
// Honours HUFF_PAD_SINGLE_EN for the single-leaf expectation.
module tb_huffman_phase_ctrl;
   import huff_pkg::*;

   logic clk = 1'b0;
   logic reset, start, HREADY, finish_cnt, leaf_ready, tree_done;
   logic [NSYM-1:0][CW-1:0] curr_count;
   logic count_clear, count_enable, leaf_valid, busy, done, error;
   logic [IW-1:0] leaf_sym;
   logic [CW-1:0] leaf_freq;
   logic [7:0] num_leaves;

   int errors = 0;
   int checks = 0;
   int exp_sym[$], exp_freq[$], obs_sym[$], obs_freq[$];

   always #5 clk = ~clk;

   huffman_phase_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .HREADY(HREADY),
      .finish_cnt(finish_cnt), .curr_count(curr_count),
      .leaf_ready(leaf_ready), .tree_done(tree_done),
      .count_clear(count_clear), .count_enable(count_enable),
      .leaf_valid(leaf_valid), .leaf_sym(leaf_sym), .leaf_freq(leaf_freq),
      .num_leaves(num_leaves), .busy(busy), .done(done), .error(error)
   );

   task automatic clear_table();
      curr_count = '0;
      exp_sym.delete(); exp_freq.delete();
      obs_sym.delete(); obs_freq.delete();
   endtask

   task automatic add_leaf(input int s, input int f);
      curr_count[s] = CW'(f);
      exp_sym.push_back(s);
      exp_freq.push_back(f);
   endtask

   // Start a pass, toggle HREADY, raise finish_cnt on the 11th cycle.
   task automatic begin_pass(output int clr, output int enbad,
                             output int err_clr);
      int exp_en;
      clr = 0; enbad = 0; err_clr = 0;
      leaf_ready = 1'b1;
      @(negedge clk); start = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         start = 1'b0;
         HREADY = k[0];
         finish_cnt = (k == 11);
         #1;
         exp_en = (k >= 2 && k <= 10) ? int'(HREADY) : 0;
         if (int'(count_enable) != exp_en) enbad++;
         if (count_clear) clr++;
         if (k == 1 && (error !== 1'b0 || done !== 1'b0)) err_clr++;
      end
      finish_cnt = 1'b0;
      HREADY = 1'b0;
   endtask

   // Drive leaf_ready and record every accepted leaf.
   task automatic collect(input int ncyc, input bit stall,
                          output int unstable);
      int w = 0;
      bit held = 0;
      logic [IW-1:0] ps = '0;
      logic [CW-1:0] pf = '0;
      unstable = 0;
      repeat (ncyc) begin
         @(negedge clk);
         if (held && (leaf_valid !== 1'b1 || leaf_sym !== ps
                      || leaf_freq !== pf)) unstable++;
         if (stall && leaf_valid && w < 4) begin
            leaf_ready = 1'b0; w++;
         end else begin
            leaf_ready = 1'b1;
         end
         #1;
         if (leaf_valid && leaf_ready) begin
            obs_sym.push_back(int'(leaf_sym));
            obs_freq.push_back(int'(leaf_freq));
            w = 0; held = 0;
         end else begin
            held = leaf_valid; ps = leaf_sym; pf = leaf_freq;
         end
      end
   endtask

   task automatic pulse_tree();
      @(negedge clk); tree_done = 1'b1;
      @(negedge clk); tree_done = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 0; HREADY = 0; finish_cnt = 0;
      leaf_ready = 0; tree_done = 0; curr_count = '0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({count_clear, count_enable, leaf_valid, busy, done, error} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctl got=%b want=000000",
                  {count_clear, count_enable, leaf_valid, busy, done, error});
      end
      checks++;
      if (leaf_sym !== '0 || leaf_freq !== '0 || num_leaves !== 8'd0) begin
         errors++;
         $display("FAIL reset_data sym=%0d freq=%0d num=%0d want 0/0/0",
                  leaf_sym, leaf_freq, num_leaves);
      end
      reset = 1'b0;
   endtask

   task automatic test_count_phase();
      int clr, enbad, ec, u;
      clear_table();
      add_leaf(3, 5);
      begin_pass(clr, enbad, ec);
      checks++;
      if (clr != 1) begin
         errors++; $display("FAIL clear_pulses got=%0d want=1", clr);
      end
      checks++;
      if (enbad != 0) begin
         errors++; $display("FAIL count_enable_mirror bad=%0d want=0", enbad);
      end
      collect(150, 0, u);
      pulse_tree();
      checks++;
      if (done !== 1'b1) begin
         errors++; $display("FAIL count_pass_done got=%b want=1", done);
      end
   endtask

   task automatic test_three_leaves(input bit stall);
      int clr, enbad, ec, u, n, s, f;
      clear_table();
      add_leaf(3, 5); add_leaf(64, 2); add_leaf(127, 9);
      begin_pass(clr, enbad, ec);
      collect(200, stall, u);
      checks++;
      if (obs_sym.size() != exp_sym.size()) begin
         errors++;
         $display("FAIL leaf_count stall=%0d got=%0d want=%0d",
                  stall, obs_sym.size(), exp_sym.size());
      end
      n = (obs_sym.size() < exp_sym.size()) ? obs_sym.size() : exp_sym.size();
      for (int i = 0; i < n; i++) begin
         s = obs_sym.pop_front(); f = obs_freq.pop_front();
         checks++;
         if (s != exp_sym[0] || f != exp_freq[0]) begin
            errors++;
            $display("FAIL leaf%0d stall=%0d got=(%0d,%0d) want=(%0d,%0d)",
                     i, stall, s, f, exp_sym[0], exp_freq[0]);
         end
         void'(exp_sym.pop_front()); void'(exp_freq.pop_front());
      end
      if (stall) begin
         checks++;
         if (u != 0) begin
            errors++; $display("FAIL stall_hold changes=%0d want=0", u);
         end
      end
      checks++;
      if (num_leaves !== 8'd3) begin
         errors++; $display("FAIL num_leaves3 got=%0d want=3", num_leaves);
      end
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL wait_tree busy=%b done=%b want 1/0", busy, done);
      end
      pulse_tree();
      checks++;
      if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL tree_done done=%b err=%b busy=%b want 1/0/0",
                  done, error, busy);
      end
   endtask

   task automatic test_all_zero();
      int clr, enbad, ec, u;
      clear_table();
      begin_pass(clr, enbad, ec);
      collect(150, 0, u);
      checks++;
      if (obs_sym.size() != 0) begin
         errors++; $display("FAIL zero_leaves got=%0d want=0", obs_sym.size());
      end
      checks++;
      if (done !== 1'b1 || error !== 1'b1 || num_leaves !== 8'd0) begin
         errors++;
         $display("FAIL zero_done done=%b err=%b num=%0d want 1/1/0",
                  done, error, num_leaves);
      end
   endtask

   task automatic test_single();
      int clr, enbad, ec, u, want_n;
      clear_table();
      add_leaf(127, 7);
`ifdef HUFF_PAD_SINGLE_EN
      exp_sym.push_back(0); exp_freq.push_back(0);
      want_n = 2;
`else
      want_n = 1;
`endif
      begin_pass(clr, enbad, ec);
      checks++;
      if (ec != 0) begin
         errors++; $display("FAIL restart_drop_error got=%0d want=0", ec);
      end
      collect(150, 0, u);
      checks++;
      if (obs_sym.size() != want_n) begin
         errors++;
         $display("FAIL single_count got=%0d want=%0d", obs_sym.size(), want_n);
      end
      while (obs_sym.size() > 0 && exp_sym.size() > 0) begin
         checks++;
         if (obs_sym[0] != exp_sym[0] || obs_freq[0] != exp_freq[0]) begin
            errors++;
            $display("FAIL single_leaf got=(%0d,%0d) want=(%0d,%0d)",
                     obs_sym[0], obs_freq[0], exp_sym[0], exp_freq[0]);
         end
         void'(obs_sym.pop_front()); void'(obs_freq.pop_front());
         void'(exp_sym.pop_front()); void'(exp_freq.pop_front());
      end
      checks++;
      if (int'(num_leaves) != want_n || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_num got=%0d busy=%b want=%0d/1",
                  num_leaves, busy, want_n);
      end
      pulse_tree();
      checks++;
      if (done !== 1'b1 || error !== 1'b0) begin
         errors++;
         $display("FAIL single_done done=%b err=%b want 1/0", done, error);
      end
   endtask

   task automatic test_reset_mid_scan();
      int clr, enbad, ec, t;
      clear_table();
      add_leaf(3, 5); add_leaf(64, 2);
      begin_pass(clr, enbad, ec);
      leaf_ready = 1'b0;
      t = 0;
      while (leaf_valid !== 1'b1 && t < 50) begin
         @(negedge clk); #1; t++;
      end
      checks++;
      if (leaf_valid !== 1'b1) begin
         errors++; $display("FAIL midscan_leaf timeout got=%b want=1", leaf_valid);
      end
      @(negedge clk); reset = 1'b1;
      @(negedge clk); #1;
      checks++;
      if (leaf_valid !== 1'b0 || num_leaves !== 8'd0 || busy !== 1'b0
          || done !== 1'b0) begin
         errors++;
         $display("FAIL midscan_reset valid=%b num=%0d busy=%b done=%b want 0",
                  leaf_valid, num_leaves, busy, done);
      end
      reset = 1'b0;
      leaf_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_count_phase();
      test_three_leaves(1'b0);
      test_three_leaves(1'b1);
      test_all_zero();
      test_single();
      test_reset_mid_scan();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/huffman_phase_ctrl.md
# huffman_phase_ctrl

Top-level phase sequencer for the Huffman encoder front end. Starts and clears the symbol-counting datapath, gates its count enable on bus readiness, and waits for the 128-entry frequency table to complete. Then walks the table one entry per cycle, streaming every non-zero (symbol, frequency) leaf to the tree builder over a valid/ready handshake. Finally waits for the tree builder to finish and reports completion.

## Interface
Parameters:
- NSYM, 128, number of symbol bins (index width = $clog2(NSYM) = 7).
- CW, 16, frequency count width.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a new encode pass; sampled only in IDLE and DONE.
- HREADY  in  1  bus ready; counting advances only while high.
- finish_cnt  in  1  counting datapath reports table complete.
- curr_count  in  [NSYM-1:0][CW-1:0]  frequency table; stable from finish_cnt until next clear.
- leaf_ready  in  1  tree builder accepts leaf.
- tree_done  in  1  tree builder finished (single-cycle pulse or level).
- count_clear  out  1  one-cycle clear to counting datapath.
- count_enable  out  1  counting enable.
- leaf_valid  out  1  leaf stream valid.
- leaf_sym  out  7  leaf symbol index.
- leaf_freq  out  CW  leaf frequency.
- num_leaves  out  8  leaves emitted this pass (0..128).
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  level, high in DONE.
- error  out  1  level, high in DONE when the pass found zero leaves.

## Operation
- States: IDLE, CLEAR, COUNT, SCAN, WAIT_TREE, DONE.
- IDLE: start=1 -> CLEAR.
- CLEAR: count_clear=1 for exactly one cycle; num_leaves, error and idx are zeroed. Next state is COUNT.
- COUNT: count_enable = HREADY (combinational). finish_cnt=1 -> SCAN with idx=0. count_enable is low in that transition cycle and in all other states.
- SCAN: one table entry is evaluated per cycle when the output slot is free. The slot is free when leaf_valid=0, or when leaf_valid & leaf_ready in this cycle.
  - If the slot is free and curr_count[idx]!=0, load leaf_sym=idx and leaf_freq=curr_count[idx], set leaf_valid=1, and increment num_leaves on load.
  - If the slot is free, idx increments whether or not the entry is zero.
  - If the slot is not free, idx holds.
  - leaf_sym and leaf_freq are held stable while leaf_valid & !leaf_ready.
- SCAN exit: occurs when idx has passed NSYM-1 and no leaf is pending, i.e. leaf_valid=0 or the final handshake happens this cycle.
  - num_leaves==0 -> DONE with error=1.
  - Otherwise -> WAIT_TREE.
- WAIT_TREE: tree_done=1 -> DONE.
- DONE: done=1. start=1 -> CLEAR, which restarts the pass and drops done and error.
- start is ignored in CLEAR, COUNT, SCAN and WAIT_TREE. finish_cnt and tree_done are ignored outside COUNT and WAIT_TREE respectively.
- idx is 8 bits wide so it can reach 128. num_leaves saturates naturally at 128 and cannot wrap.

## Timing
- Reset values: state=IDLE. All outputs are 0: count_clear, count_enable, leaf_valid, leaf_sym, leaf_freq, num_leaves, busy, done, error.
- Reset asserted mid-pass returns to IDLE on the next edge and drops leaf_valid immediately, with no handshake completion.
- start in IDLE -> count_clear high in the next cycle -> COUNT the cycle after.
- finish_cnt -> first leaf_valid no earlier than 2 cycles later (SCAN entry, then leaf register).
- Full scan with leaf_ready tied high takes NSYM+1 cycles in SCAN, independent of leaf count.
- WAIT_TREE -> DONE is one cycle after tree_done is sampled.

## Configuration
- HUFF_PAD_SINGLE_EN defined:
  - When SCAN ends with num_leaves==1, one pad leaf is emitted before leaving SCAN.
  - Pad leaf: leaf_sym = (last leaf_sym+1) mod 128, leaf_freq = 0.
  - num_leaves becomes 2. The tree builder therefore always receives at least two leaves.
- Not defined: a single-leaf pass goes straight to WAIT_TREE with num_leaves=1.
- A zero-leaf pass reports error in both builds.

## Structure
- Shared package huff_pkg holds:
  - NSYM, CW and the symbol index width constant.
  - The state enum type huff_phase_t.
  - The packed leaf struct huff_leaf_t {sym, freq}.
- One sub-module: leaf_out_reg. It is the single-entry valid/ready output register with hold-while-stalled behaviour, and it produces the slot-free signal back to the FSM.
- The FSM, idx and num_leaves live in huffman_phase_ctrl itself.

## Test plan
- Reset mid-SCAN with leaf_valid=1 -> next cycle: state IDLE, leaf_valid=0, num_leaves=0, busy=0.
- start, HREADY toggling 1/0, finish_cnt after 10 cycles:
  - count_clear pulses exactly once.
  - count_enable mirrors HREADY only in COUNT.
- Table with counts[3]=5, counts[64]=2, counts[127]=9, leaf_ready=1:
  - Leaves (3,5), (64,2), (127,9) in order.
  - num_leaves=3.
  - WAIT_TREE reached; tree_done -> done=1, error=0.
- Same table with leaf_ready low for 4 cycles on each leaf -> sym and freq held stable while stalled, no leaf lost or duplicated, num_leaves=3.
- All-zero table -> no leaf_valid, DONE with error=1, num_leaves=0.
- Only counts[127]=7:
  - With HUFF_PAD_SINGLE_EN: leaves (127,7) then (0,0), num_leaves=2.
  - Without it: one leaf, num_leaves=1.
